// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 pipeline: stage hold/flush controls,
// EX operand forwarding selects, mul/div EX occupancy sequencing and dmem-wait freeze.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_muldiv,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             hold_pc,
    output logic             hold_ifid,
    output logic             hold_idex,
    output logic             hold_exmem,
    output logic             hold_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             muldiv_busy,
    output logic [31:0]      stall_cycles
);

    typedef enum logic {RUN, MDIV} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      r_stall;
    logic             w_freeze;
    logic             w_load_use;

    assign w_freeze   = mem_access & ~dmem_ready;
    assign w_load_use = ex_mem_read & ex_reg_write & (ex_rd != 5'd0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) |
                         (id_use_rs2 & (id_rs2 == ex_rd)));

    // Priority: freeze > redirect > mul/div sequencing > load-use.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        hold_pc     = 1'b0;
        hold_ifid   = 1'b0;
        hold_idex   = 1'b0;
        hold_exmem  = 1'b0;
        hold_memwb  = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        if (!RST) begin
            if (w_freeze) begin
                hold_pc    = 1'b1;
                hold_ifid  = 1'b1;
                hold_idex  = 1'b1;
                hold_exmem = 1'b1;
                hold_memwb = 1'b1;
            end else if (ex_redirect) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (r_state == MDIV) begin
                if (r_cnt != '0) begin
                    hold_pc     = 1'b1;
                    hold_ifid   = 1'b1;
                    hold_idex   = 1'b1;
                    flush_exmem = 1'b1;
                    w_cnt_nxt   = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = RUN;
                end
            end else if (ex_muldiv) begin
                hold_pc     = 1'b1;
                hold_ifid   = 1'b1;
                hold_idex   = 1'b1;
                flush_exmem = 1'b1;
                w_cnt_nxt   = CNT_W'(MULDIV_LAT - 2);
                w_state_nxt = MDIV;
            end else if (w_load_use) begin
                hold_pc    = 1'b1;
                hold_ifid  = 1'b1;
                flush_idex = 1'b1;
            end
        end
    end

    // MEM result is younger than WB, so it wins when both match; x0 never forwards.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!RST) begin
            if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs1))
                fwd_a = 2'b10;
            else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
                fwd_a = 2'b01;
            if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs2))
                fwd_b = 2'b10;
            else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
                fwd_b = 2'b01;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (hold_pc && (r_stall != '1))
                r_stall <= r_stall + 32'd1;
        end
    end

    assign muldiv_busy  = ~RST & (r_state == MDIV);
    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (MULDIV_LAT=4): expected controls are
// queued as each step is driven and compared on the following falling edge.
module tb_pipeline_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, ex_muldiv, ex_redirect;
    logic        mem_reg_write, mem_access, dmem_ready, wb_reg_write;
    logic [1:0]  fwd_a, fwd_b;
    logic        hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb;
    logic        flush_ifid, flush_idex, flush_exmem, muldiv_busy;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [12:0] ctl;
        logic [31:0] stall;
    } exp_t;

    exp_t sb[$];

    // Hold vector order {pc,ifid,idex,exmem,memwb}; flush order {ifid,idex,exmem}
    localparam logic [4:0] H_NONE = 5'b00000;
    localparam logic [4:0] H_LU   = 5'b11000;
    localparam logic [4:0] H_MD   = 5'b11100;
    localparam logic [4:0] H_ALL  = 5'b11111;
    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_LU   = 3'b010;
    localparam logic [2:0] F_MD   = 3'b001;
    localparam logic [2:0] F_RD   = 3'b110;

    pipeline_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_access(mem_access),
        .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .hold_pc(hold_pc), .hold_ifid(hold_ifid), .hold_idex(hold_idex),
        .hold_exmem(hold_exmem), .hold_memwb(hold_memwb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RST === 1'b0)
            assert (!(ex_redirect && ex_muldiv))
            else $error("FAIL stim_redirect_muldiv observed 1 required 0");
    end

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_muldiv = 1'b0; ex_redirect = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
        wb_rd = '0; wb_reg_write = 1'b0;
    endtask

    task automatic load_use_rs2_5();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
        id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    endtask

    // Queue the expectation for the currently driven inputs, then compare at the falling edge.
    task automatic step(input int id, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [4:0] h, input logic [2:0] f, input logic busy,
                        input logic [31:0] st);
        exp_t e;
        exp_t g;
        logic [12:0] obs;
        e.id = id;
        e.ctl = {fa, fb, h, f, busy};
        e.stall = st;
        sb.push_back(e);
        @(negedge CLK);
        g = sb.pop_front();
        obs = {fwd_a, fwd_b, hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb,
               flush_ifid, flush_idex, flush_exmem, muldiv_busy};
        checks++;
        assert (obs === g.ctl)
        else begin
            errors++;
            $error("FAIL step%0d_ctl observed %b expected %b", g.id, obs, g.ctl);
        end
        checks++;
        assert (stall_cycles === g.stall)
        else begin
            errors++;
            $error("FAIL step%0d_stall observed %0d expected %0d", g.id, stall_cycles, g.stall);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        ex_rs1 = 5'd7; mem_rd = 5'd7; mem_reg_write = 1'b1;
        mem_access = 1'b1; dmem_ready = 1'b0;
        load_use_rs2_5();
        @(posedge CLK);
        #1;
        // Reset gates every control even with hazards and freeze present
        step(1, 2'b00, 2'b00, H_NONE, F_NONE, 1'b0, 0);

        RST = 1'b0;
        idle();
        step(2, 2'b00, 2'b00, H_NONE, F_NONE, 1'b0, 0);
        load_use_rs2_5();
        step(3, 2'b00, 2'b00, H_LU, F_LU, 1'b0, 0);
        idle();
        step(4, 2'b00, 2'b00, H_NONE, F_NONE, 1'b0, 1);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0;
        id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        step(5, 2'b00, 2'b00, H_NONE, F_NONE, 1'b0, 1);

        idle();
        ex_rs1 = 5'd7; ex_rs2 = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
        mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        step(6, 2'b10, 2'b10, H_NONE, F_NONE, 1'b0, 1);
        mem_reg_write = 1'b0;
        step(7, 2'b01, 2'b01, H_NONE, F_NONE, 1'b0, 1);
        ex_rs1 = 5'd0; mem_rd = 5'd0; mem_reg_write = 1'b1;
        step(8, 2'b00, 2'b01, H_NONE, F_NONE, 1'b0, 1);

        idle();
        ex_muldiv = 1'b1;
        step(9,  2'b00, 2'b00, H_MD, F_MD, 1'b0, 1);
        step(10, 2'b00, 2'b00, H_MD, F_MD, 1'b1, 2);
        step(11, 2'b00, 2'b00, H_MD, F_MD, 1'b1, 3);
        step(12, 2'b00, 2'b00, H_NONE, F_NONE, 1'b1, 4);
        ex_muldiv = 1'b0;
        step(13, 2'b00, 2'b00, H_NONE, F_NONE, 1'b0, 4);

        ex_muldiv = 1'b1;
        step(14, 2'b00, 2'b00, H_MD, F_MD, 1'b0, 4);
        step(15, 2'b00, 2'b00, H_MD, F_MD, 1'b1, 5);
        mem_access = 1'b1; dmem_ready = 1'b0;
        step(16, 2'b00, 2'b00, H_ALL, F_NONE, 1'b1, 6);
        step(17, 2'b00, 2'b00, H_ALL, F_NONE, 1'b1, 7);
        mem_access = 1'b0; dmem_ready = 1'b1;
        step(18, 2'b00, 2'b00, H_MD, F_MD, 1'b1, 8);
        step(19, 2'b00, 2'b00, H_NONE, F_NONE, 1'b1, 9);
        ex_muldiv = 1'b0;
        step(20, 2'b00, 2'b00, H_NONE, F_NONE, 1'b0, 9);

        load_use_rs2_5();
        ex_redirect = 1'b1;
        step(21, 2'b00, 2'b00, H_NONE, F_RD, 1'b0, 9);
        mem_access = 1'b1; dmem_ready = 1'b0;
        step(22, 2'b00, 2'b00, H_ALL, F_NONE, 1'b0, 9);
        idle();
        mem_access = 1'b1; dmem_ready = 1'b1;
        step(23, 2'b00, 2'b00, H_NONE, F_NONE, 1'b0, 10);

        idle();
        ex_muldiv = 1'b1;
        step(24, 2'b00, 2'b00, H_MD, F_MD, 1'b0, 10);
        step(25, 2'b00, 2'b00, H_MD, F_MD, 1'b1, 11);
        RST = 1'b1;
        step(26, 2'b00, 2'b00, H_NONE, F_NONE, 1'b0, 12);
        RST = 1'b0;
        ex_muldiv = 1'b0;
        step(27, 2'b00, 2'b00, H_NONE, F_NONE, 1'b0, 0);

        ex_muldiv = 1'b1;
        step(28, 2'b00, 2'b00, H_MD, F_MD, 1'b0, 0);
        step(29, 2'b00, 2'b00, H_MD, F_MD, 1'b1, 1);
        step(30, 2'b00, 2'b00, H_MD, F_MD, 1'b1, 2);
        step(31, 2'b00, 2'b00, H_NONE, F_NONE, 1'b1, 3);
        step(32, 2'b00, 2'b00, H_MD, F_MD, 1'b0, 3);

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_drain observed %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
